// File: rtl/aes128_decrypt_iter_if.sv
// Bus bundle for the iterative AES-128 decryptor.
// Handshake: a block is accepted on a rising edge where start && in_ready;
// in_ready stays low (busy high) until the result is produced, and out_valid
// pulses for one cycle with plaintext, which is then held until the next pulse.
interface aes128_decrypt_iter_if;
   logic         start;
   logic [127:0] ciphertext;
   logic [127:0] key;
   logic         in_ready;
   logic         busy;
   logic         out_valid;
   logic [127:0] plaintext;
   logic [1:0]   dbgState;

   modport master (output start, ciphertext, key,
                   input  in_ready, busy, out_valid, plaintext, dbgState);
   modport slave  (input  start, ciphertext, key,
                   output in_ready, busy, out_valid, plaintext, dbgState);
endinterface

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock. The key schedule is
// run forward to rk10 (EXPAND), then stepped backward alongside the rounds.
// Optional feature macro: AES_DEC_KEY_CACHE_EN (reuses rk10 for a repeated key).
module aes128_decrypt_iter (
   input logic clk,
   input logic reset_n,
   aes128_decrypt_iter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, ROUND = 2'd2, FINAL = 2'd3} fsmState_t;

   fsmState_t state, stateNext;
   logic [127:0] stReg, stNext, keyReg, keyNext, ptReg, ptNext;
   logic [3:0]   roundCnt, cntNext;
   logic         ovReg, ovNext, inReadyReg, busyReg;
   logic [127:0] fwdKey, invKey, invCore;
`ifdef AES_DEC_KEY_CACHE_EN
   logic [127:0] cacheKey, cacheKeyNext, cacheRk10, cacheRk10Next;
   logic         cacheValid, cacheValidNext;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] r, p;
      r = 8'h01;
      p = x;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) r = gmul(r, p);
         p = gmul(p, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] v;
      v = ginv(x);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] invSbox(input logic [7:0] s);
      return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] keyStepFwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ subWord({k[23:0], k[31:24]}) ^ {rc, 24'h0};
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] keyStepInv(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] p0, p1, p2, p3;
      p3 = k[31:0] ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ subWord({p3[23:0], p3[31:24]}) ^ {rc, 24'h0};
      return {p0, p1, p2, p3};
   endfunction

   // Byte i (column-major, i = row + 4*col) sits at bits [127-8i -: 8].
   function automatic logic [127:0] invShiftSub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8 * (r + 4 * c) -: 8] = invSbox(s[127 - 8 * (r + 4 * ((c - r) & 3)) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] invMixColumns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32 * c -: 8];
         a1 = s[119 - 32 * c -: 8];
         a2 = s[111 - 32 * c -: 8];
         a3 = s[103 - 32 * c -: 8];
         o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Shared round datapath: roundCnt is the Rcon index in EXPAND and r elsewhere.
   always_comb begin
      fwdKey  = keyStepFwd(keyReg, rcon(roundCnt));
      invKey  = keyStepInv(keyReg, rcon(roundCnt + 4'd1));
      invCore = invShiftSub(stReg);
   end

   // Next-state and next-register values for every FSM state.
   always_comb begin
      stateNext = state;
      stNext    = stReg;
      keyNext   = keyReg;
      cntNext   = roundCnt;
      ptNext    = ptReg;
      ovNext    = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cacheKeyNext   = cacheKey;
      cacheRk10Next  = cacheRk10;
      cacheValidNext = cacheValid;
`endif
      case (state)
         IDLE: begin
            if (bus.start) begin
               stNext    = bus.ciphertext;
               keyNext   = bus.key;
               cntNext   = 4'd1;
               stateNext = EXPAND;
`ifdef AES_DEC_KEY_CACHE_EN
               if (cacheValid && (bus.key == cacheKey)) begin
                  keyNext   = cacheRk10;
                  stNext    = bus.ciphertext ^ cacheRk10;
                  cntNext   = 4'd9;
                  stateNext = ROUND;
               end else begin
                  // Entry is rewritten for the new key; only valid once rk10 lands.
                  cacheKeyNext   = bus.key;
                  cacheValidNext = 1'b0;
               end
`endif
            end
         end
         EXPAND: begin
            keyNext = fwdKey;
            cntNext = roundCnt + 4'd1;
            if (roundCnt == 4'd10) begin
               stNext    = stReg ^ fwdKey;
               cntNext   = 4'd9;
               stateNext = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
               cacheRk10Next  = fwdKey;
               cacheValidNext = 1'b1;
`endif
            end
         end
         ROUND: begin
            keyNext = invKey;
            stNext  = invMixColumns(invCore ^ invKey);
            cntNext = roundCnt - 4'd1;
            if (roundCnt == 4'd1) stateNext = FINAL;
         end
         FINAL: begin
            keyNext   = invKey;
            ptNext    = invCore ^ invKey;
            ovNext    = 1'b1;
            cntNext   = 4'd0;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= stateNext;
   end

   // Datapath and registered outputs; handshake flags follow the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stReg      <= '0;
         keyReg     <= '0;
         roundCnt   <= '0;
         ptReg      <= '0;
         ovReg      <= 1'b0;
         inReadyReg <= 1'b1;
         busyReg    <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
         cacheKey   <= '0;
         cacheRk10  <= '0;
         cacheValid <= 1'b0;
`endif
      end else begin
         stReg      <= stNext;
         keyReg     <= keyNext;
         roundCnt   <= cntNext;
         ptReg      <= ptNext;
         ovReg      <= ovNext;
         inReadyReg <= (stateNext == IDLE);
         busyReg    <= (stateNext != IDLE);
`ifdef AES_DEC_KEY_CACHE_EN
         cacheKey   <= cacheKeyNext;
         cacheRk10  <= cacheRk10Next;
         cacheValid <= cacheValidNext;
`endif
      end
   end

   assign bus.in_ready  = inReadyReg;
   assign bus.busy      = busyReg;
   assign bus.out_valid = ovReg;
   assign bus.plaintext = ptReg;
   assign bus.dbgState  = state;
endmodule
